// File: rtl/fir_coeff_loader.sv
// Coefficient-update initiator for the reconfigurable FIR filter.
// Accepts a host coefficient stream over valid/ready and writes each word into
// the positive or negative coefficient bank, one clock after acceptance.
// A reload only starts on a sample strobe so it never lands inside a MAC run.
module fir_coeff_loader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int POS_DEPTH = 7,
    parameter int NEG_DEPTH = 5,
    parameter int CNT_W     = 6
) (
    input  logic              iClk_12M,
    input  logic              iRst,
    input  logic              iEnSample_600k,
    input  logic              iUpdateReq,
    input  logic [CNT_W-1:0]  iNumCoeff,
    input  logic              iAbort,
    input  logic              iCoeffValid,
    input  logic              iCoeffNeg,
    input  logic [DATA_W-1:0] iCoeffData,
    output logic              oCoeffReady,
    output logic              oCoeffiUpdateFlag,
    output logic              oCsnRam,
    output logic              oWrnRam,
    output logic [ADDR_W-1:0] oAddrRam_pos,
    output logic [ADDR_W-1:0] oAddrRam_neg,
    output logic [DATA_W-1:0] oWrDtRam,
    output logic [CNT_W-1:0]  oNumOfCoeff,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SMP = 2'd1,
        LOAD     = 2'd2,
        FINISH   = 2'd3
    } state_t;

    // Bank pointers carry one extra bit so "one past the last legal address"
    // is representable and overflow is a simple magnitude compare.
    localparam logic [ADDR_W:0]  POS_LIM  = POS_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]  NEG_LIM  = NEG_DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t              state_q;
    logic [CNT_W-1:0]    total_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    wrCnt_q;
    logic [ADDR_W:0]     posPtr_q;
    logic [ADDR_W:0]     negPtr_q;

    logic                ready_q;
    logic                flag_q;
    logic                csn_q;
    logic                wrn_q;
    logic [ADDR_W-1:0]   addrPos_q;
    logic [ADDR_W-1:0]   addrNeg_q;
    logic [DATA_W-1:0]   wrDt_q;
    logic [CNT_W-1:0]    numCoeff_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;

    logic                accept_d;
    logic                overflow_d;
    logic                lastWord_d;
    logic [CNT_W-1:0]    cnt_d;
    logic [CNT_W-1:0]    wrCnt_d;
    logic [ADDR_W:0]     posPtr_d;
    logic [ADDR_W:0]     negPtr_d;

    // Handshake decode and the incremented counters/pointers for an accepted word.
    always_comb begin
        accept_d   = (state_q == LOAD) && ready_q && iCoeffValid;
        overflow_d = iCoeffNeg ? (negPtr_q > NEG_LIM) : (posPtr_q > POS_LIM);
        cnt_d      = cnt_q + CNT_ONE;
        wrCnt_d    = wrCnt_q + CNT_ONE;
        posPtr_d   = posPtr_q + PTR_ONE;
        negPtr_d   = negPtr_q + PTR_ONE;
        lastWord_d = (cnt_d == total_q);
    end

    // Reload sequencer; every port value is produced here as a registered output.
    always_ff @(posedge iClk_12M) begin
        if (iRst) begin
            state_q    <= IDLE;
            total_q    <= '0;
            cnt_q      <= '0;
            wrCnt_q    <= '0;
            posPtr_q   <= PTR_ONE;
            negPtr_q   <= PTR_ONE;
            ready_q    <= 1'b0;
            flag_q     <= 1'b0;
            csn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            addrPos_q  <= '0;
            addrNeg_q  <= '0;
            wrDt_q     <= '0;
            numCoeff_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    csn_q     <= 1'b1;
                    wrn_q     <= 1'b1;
                    addrPos_q <= '0;
                    addrNeg_q <= '0;
                    flag_q    <= 1'b0;
                    ready_q   <= 1'b0;
                    if (iUpdateReq) begin
                        err_q <= 1'b0;
                        if (iNumCoeff != CNT_ZERO) begin
                            total_q  <= iNumCoeff;
                            cnt_q    <= '0;
                            wrCnt_q  <= '0;
                            posPtr_q <= PTR_ONE;
                            negPtr_q <= PTR_ONE;
                            busy_q   <= 1'b1;
                            state_q  <= WAIT_SMP;
                        end else begin
                            // Empty reload completes at once without touching the RAM.
                            numCoeff_q <= '0;
                            done_q     <= 1'b1;
                        end
                    end
                end

                WAIT_SMP: begin
                    if (iAbort) begin
                        flag_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        csn_q     <= 1'b1;
                        wrn_q     <= 1'b1;
                        addrPos_q <= '0;
                        addrNeg_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (iEnSample_600k) begin
                        flag_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= LOAD;
                    end
                end

                LOAD: begin
                    if (iAbort) begin
                        // Abort wins over a word offered in the same cycle.
                        flag_q    <= 1'b0;
                        ready_q   <= 1'b0;
                        csn_q     <= 1'b1;
                        wrn_q     <= 1'b1;
                        addrPos_q <= '0;
                        addrNeg_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else if (accept_d) begin
                        cnt_q <= cnt_d;
                        if (overflow_d) begin
                            // Word is acknowledged and counted but never reaches the RAM.
                            err_q     <= 1'b1;
                            csn_q     <= 1'b1;
                            wrn_q     <= 1'b1;
                            addrPos_q <= '0;
                            addrNeg_q <= '0;
                        end else begin
                            csn_q   <= 1'b0;
                            wrn_q   <= 1'b0;
                            wrDt_q  <= iCoeffData;
                            wrCnt_q <= wrCnt_d;
                            if (iCoeffNeg) begin
                                addrNeg_q <= negPtr_q[ADDR_W-1:0];
                                addrPos_q <= '0;
                                negPtr_q  <= negPtr_d;
                            end else begin
                                addrPos_q <= posPtr_q[ADDR_W-1:0];
                                addrNeg_q <= '0;
                                posPtr_q  <= posPtr_d;
                            end
                        end
                        if (lastWord_d) begin
                            ready_q <= 1'b0;
                            state_q <= FINISH;
                        end
                    end else begin
                        csn_q     <= 1'b1;
                        wrn_q     <= 1'b1;
                        addrPos_q <= '0;
                        addrNeg_q <= '0;
                    end
                end

                FINISH: begin
                    csn_q      <= 1'b1;
                    wrn_q      <= 1'b1;
                    addrPos_q  <= '0;
                    addrNeg_q  <= '0;
                    flag_q     <= 1'b0;
                    ready_q    <= 1'b0;
                    numCoeff_q <= wrCnt_q;
                    done_q     <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oCoeffReady       = ready_q;
    assign oCoeffiUpdateFlag = flag_q;
    assign oCsnRam           = csn_q;
    assign oWrnRam           = wrn_q;
    assign oAddrRam_pos      = addrPos_q;
    assign oAddrRam_neg      = addrNeg_q;
    assign oWrDtRam          = wrDt_q;
    assign oNumOfCoeff       = numCoeff_q;
    assign oBusy             = busy_q;
    assign oDone             = done_q;
    assign oErr              = err_q;

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Initiator side of the reconfigurable FIR filter's coefficient-update interface.
- Takes a coefficient stream from a host over a valid/ready handshake. Drives the filter's update flag, RAM chip-select, write-enable, positive/negative bank addresses, write data and coefficient count.
- Sorts each word into the positive or negative bank by its sign tag and assigns consecutive addresses per bank, starting at 1.
- Starts only on a 600 kHz sample strobe, so a reload never lands inside a running MAC sequence.

Parameters:
- ADDR_W, 4, width of each bank address; address 0 means "no access".
- DATA_W, 16, coefficient word width.
- POS_DEPTH, 7, highest legal positive-bank address.
- NEG_DEPTH, 5, highest legal negative-bank address.
- CNT_W, 6, width of coefficient count.

Ports:
- iClk_12M  in  1  12 MHz system clock; all logic on rising edge.
- iRst  in  1  synchronous, active-high reset.
- iEnSample_600k  in  1  sample strobe, one clock wide.
- iUpdateReq  in  1  one-cycle request to start a reload.
- iNumCoeff  in  CNT_W  total words to load; sampled with iUpdateReq.
- iAbort  in  1  cancels an active reload.
- iCoeffValid  in  1  host word valid.
- iCoeffNeg  in  1  1 = word goes to negative bank.
- iCoeffData  in  DATA_W  coefficient magnitude.
- oCoeffReady  out  1  loader accepts a word this cycle.
- oCoeffiUpdateFlag  out  1  high for the whole reload window.
- oCsnRam  out  1  RAM chip-select, active low.
- oWrnRam  out  1  RAM write-enable, active low.
- oAddrRam_pos  out  ADDR_W  positive-bank address.
- oAddrRam_neg  out  ADDR_W  negative-bank address.
- oWrDtRam  out  DATA_W  write data.
- oNumOfCoeff  out  CNT_W  number of words written in the last completed reload.
- oBusy  out  1  FSM not in IDLE.
- oDone  out  1  one-cycle pulse on completion.
- oErr  out  1  sticky bank-overflow flag; cleared by the next accepted request.

Behaviour:
- All outputs are registered. Reset (iRst=1 at a clock edge) forces:
  - oCsnRam=1, oWrnRam=1;
  - flag, ready, busy, done, err = 0;
  - both addresses = 0, data = 0, oNumOfCoeff = 0;
  - FSM to IDLE.
- Reset mid-reload abandons the reload with no oDone pulse.
- States: IDLE, WAIT_SMP, LOAD, FINISH.
- IDLE:
  - iUpdateReq=1 with iNumCoeff>0 → latch iNumCoeff, clear oErr, clear both pointers to 1, go to WAIT_SMP.
  - iUpdateReq=1 with iNumCoeff=0 → oDone pulses next cycle; flag never rises; oNumOfCoeff=0; stay IDLE.
- WAIT_SMP: on iEnSample_600k=1 → LOAD. oCoeffiUpdateFlag=1 and oCoeffReady=1 from the next cycle.
- LOAD, accepted word (iCoeffValid & oCoeffReady):
  - Next cycle: oCsnRam=0, oWrnRam=0, oWrDtRam=iCoeffData.
  - Selected bank address = its pointer; other bank address = 0.
  - Selected pointer increments; count increments.
- LOAD, no word accepted: next cycle oCsnRam=1, oWrnRam=1, both addresses = 0. Bubbles are legal and unlimited.
- Overflow: a word whose bank pointer already exceeds its depth is still counted and acknowledged, but not written (Csn/Wrn stay 1). oErr=1 and stays set.
- On the cycle the count reaches the latched total:
  - oCoeffReady drops the following cycle; FSM → FINISH.
  - The final write still appears on the port in that cycle.
- FINISH (one cycle):
  - oCsnRam=1, oWrnRam=1, addresses = 0, flag = 0.
  - oDone=1; oNumOfCoeff = count of words actually written (overflowed words excluded).
  - Then → IDLE.
- iAbort in WAIT_SMP or LOAD:
  - Next cycle: flag=0, Csn/Wrn=1, ready=0, → IDLE.
  - No oDone; oNumOfCoeff unchanged.
  - iAbort has priority over a simultaneous accepted word; that word is not written.
- iUpdateReq while oBusy=1 is ignored.
- iEnSample_600k has no effect outside WAIT_SMP.
- Latency:
  - host handshake → RAM write cycle: 1 clock;
  - request → flag high: wait for strobe + 1 clock.

Test Plan:
- Request with N=12; strobe after 5 cycles; valid held high; signs alternate +,−,… with the last two both +; data 0x0003,0x0006,0x0007,0x000B,0x000D,0x0013,0x0018,0x0025,0x0030,0x0066,0x00CE,0x01F4 → pos addresses 1..7, neg addresses 1..5, each write one cycle after acceptance; oDone once; oNumOfCoeff=12; oErr=0.
- Same load with iCoeffValid toggling every other cycle → bubble cycles show Csn/Wrn=1 and addresses 0; final RAM contents and oNumOfCoeff=12 unchanged.
- Eight positive words with POS_DEPTH=7 → seven writes at addresses 1..7; 8th acknowledged with no write; oErr=1; oNumOfCoeff=7.
- iAbort asserted after 3 accepted words → flag low next cycle; no oDone; a further iUpdateReq starts cleanly with pointers at 1 and oErr cleared.
- iRst asserted in LOAD → all outputs at reset values next cycle; iUpdateReq with N=0 → oDone pulse with no flag or RAM activity.
- Second iUpdateReq during WAIT_SMP ignored; iEnSample_600k during LOAD ignored; exactly N writes occur.
